// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared constants, types and helpers for the TMDS encoder
//
// Purpose: one place for the symbol width, the default disparity counter
// width, the four DVI control symbols and the small helpers used by both
// pipeline stages.
// Ports: none (package).
package tmds_pkg;

  localparam int SYM_W              = 10;
  localparam int DISP_WIDTH_DEFAULT = 5;

  // Control symbols sent during blanking, indexed by {C1,C0}.
  localparam logic [SYM_W-1:0] CTRL_SYM_00 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_SYM_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_SYM_10 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_SYM_11 = 10'h2AB;

  // Which of the three DC-balancing rules stage 2 applies to a data word.
  typedef enum logic [1:0] {
    DISP_A = 2'd0,  // counter neutral or word balanced: invert only on XNOR path
    DISP_B = 2'd1,  // word would worsen the running imbalance: send inverted
    DISP_C = 2'd2   // word already pulls toward balance: send as is
  } disp_case_e;

  // Stage-1 pipeline register contents.
  typedef struct packed {
    logic       de;
    logic [1:0] ctrl;
    logic [8:0] qm;
  } stage1_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_symbol(input logic [1:0] c);
    logic [SYM_W-1:0] s;
    case (c)
      2'b00:   s = CTRL_SYM_00;
      2'b01:   s = CTRL_SYM_01;
      2'b10:   s = CTRL_SYM_10;
      default: s = CTRL_SYM_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_minimize.sv
// rtl/tmds_minimize.sv - combinational transition-minimizing qm generator
//
// Purpose: turns a pixel byte into the 9-bit transition-minimized word qm.
// qm[8] records which path was used (1 = XOR, 0 = XNOR).
// Ports:
//   data  in   8  pixel component
//   qm    out  9  minimized word
module tmds_minimize
  import tmds_pkg::*;
(
  input  logic [7:0] data,
  output logic [8:0] qm
);

  logic [3:0] n1d;

  assign n1d = popcount8(data);

  always_comb begin : minimize
    logic       use_xnor;
    logic [8:0] q;
    // Tie-break on data[0] when the byte is balanced.
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
    q        = '0;
    q[0]     = data[0];
    // XNOR is XOR followed by inversion, so both paths share one chain.
    for (int i = 1; i < 8; i++) begin
      q[i] = q[i-1] ^ data[i] ^ use_xnor;
    end
    q[8] = ~use_xnor;
    qm   = q;
  end

endmodule

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - two-stage DVI TMDS 8b/10b encoder for one channel
//
// Purpose: stage 1 registers the minimized word with de/ctrl; stage 2 applies
// DC balancing against the running disparity counter (or emits a control
// symbol in blanking) and registers the 10-bit symbol. Latency 2 clocks,
// one symbol per clock. DISP_WIDTH must be at least 5 so the counter
// (bounded to +/-10) cannot wrap.
// Ports:
//   clock    in   1   pixel clock
//   resetN   in   1   asynchronous active-low reset
//   de       in   1   1 = active video, 0 = blanking
//   ctrl     in   2   {C1,C0}, used only when de=0
//   data     in   8   pixel component, used only when de=1
//   tmdsOut  out  10  encoded symbol, bit 0 sent first
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int DISP_WIDTH = DISP_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             de,
  input  logic [1:0]       ctrl,
  input  logic [7:0]       data,
  output logic [SYM_W-1:0] tmdsOut
);

  localparam logic signed [DISP_WIDTH-1:0] TWO  = DISP_WIDTH'(2);
  localparam logic signed [DISP_WIDTH-1:0] ZERO = '0;
  localparam logic signed [DISP_WIDTH+1:0] CNT_LIMIT = (DISP_WIDTH+2)'(10);

  // ---------------- stage 1 ----------------
  logic [8:0] qm_comb;
  stage1_t    s1_q;

  tmds_minimize u_minimize (
    .data (data),
    .qm   (qm_comb)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_q <= '0;
    end else begin
      s1_q.de   <= de;
      s1_q.ctrl <= ctrl;
      s1_q.qm   <= qm_comb;
    end
  end

  // ---------------- stage 2 ----------------
  logic                         q8;
  logic [7:0]                   qlo;
  logic [3:0]                   n1;
  logic signed [DISP_WIDTH-1:0] diff;     // N1 - N0 of qm[7:0]
  logic signed [DISP_WIDTH-1:0] delta;
  logic signed [DISP_WIDTH-1:0] cnt_q;
  logic signed [DISP_WIDTH-1:0] cnt_d;
  logic signed [DISP_WIDTH+1:0] cnt_wide; // overflow-free next count
  disp_case_e                   sel;
  logic [SYM_W-1:0]             sym_active;
  logic [SYM_W-1:0]             sym_d;

  assign q8  = s1_q.qm[8];
  assign qlo = s1_q.qm[7:0];
  assign n1  = popcount8(qlo);

  always_comb begin
    diff = DISP_WIDTH'(2 * int'(n1) - 8);
    sel  = DISP_C;
    if ((cnt_q == ZERO) || (n1 == 4'd4)) begin
      sel = DISP_A;
    end else if ((!cnt_q[DISP_WIDTH-1] && (n1 > 4'd4)) ||
                 ( cnt_q[DISP_WIDTH-1] && (n1 < 4'd4))) begin
      // cnt is known non-zero here, so the sign bit alone separates >0 / <0.
      sel = DISP_B;
    end
  end

  always_comb begin
    sym_active = '0;
    delta      = ZERO;
    case (sel)
      DISP_A: begin
        sym_active = {~q8, q8, q8 ? qlo : ~qlo};
        delta      = q8 ? diff : -diff;
      end
      DISP_B: begin
        sym_active = {1'b1, q8, ~qlo};
        delta      = (q8 ? TWO : ZERO) - diff;
      end
      default: begin
        sym_active = {1'b0, q8, qlo};
        delta      = diff - (q8 ? ZERO : TWO);
      end
    endcase
  end

  always_comb begin
    if (s1_q.de) begin
      cnt_d = cnt_q + delta;
      sym_d = sym_active;
    end else begin
      // Blanking always restarts the disparity from neutral.
      cnt_d = ZERO;
      sym_d = ctrl_symbol(s1_q.ctrl);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q   <= ZERO;
      tmdsOut <= CTRL_SYM_00;
    end else begin
      cnt_q   <= cnt_d;
      tmdsOut <= sym_d;
    end
  end

  assign cnt_wide = (DISP_WIDTH+2)'(cnt_q) + (DISP_WIDTH+2)'(delta);

  a_cnt_range : assert property (
    @(posedge clock) disable iff (!resetN)
    s1_q.de |-> ((cnt_wide <= CNT_LIMIT) && (cnt_wide >= -CNT_LIMIT))
  );

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - scoreboard testbench for tmds_encoder
module tb_tmds_encoder;

  logic       clock = 1'b0;
  logic       resetN;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic [9:0] tmdsOut;

  tmds_encoder #(.DISP_WIDTH(5)) dut (
    .clock   (clock),
    .resetN  (resetN),
    .de      (de),
    .ctrl    (ctrl),
    .data    (data),
    .tmdsOut (tmdsOut)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] sym;
    bit         act;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   drv_valid = 1'b0;
  bit   v1 = 1'b0;
  bit   v2 = 1'b0;
  int   bal = 0;
  int   m_cnt = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: tmdsOut=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: integer disparity arithmetic straight from the DVI rules.
  function automatic logic [9:0] ref_sym(input bit de_i, input bit [1:0] c, input bit [7:0] d);
    int        n1d, n1, n0, qb;
    bit        inv;
    bit [8:0]  q;
    bit [9:0]  s;
    if (!de_i) begin
      m_cnt = 0;
      case (c)
        2'b00: return 10'h354;
        2'b01: return 10'h0AB;
        2'b10: return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1d  = $countones(d);
    inv  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = inv ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !inv;
    qb   = q[8] ? 1 : 0;
    n1   = $countones(q[7:0]);
    n0   = 8 - n1;
    if (m_cnt == 0 || n1 == n0) begin
      s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      m_cnt += (qb == 1) ? (n1 - n0) : (n0 - n1);
    end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
      s = {1'b1, q[8], ~q[7:0]};
      m_cnt += 2 * qb + (n0 - n1);
    end else begin
      s = {1'b0, q[8], q[7:0]};
      m_cnt += (n1 - n0) - 2 * (1 - qb);
    end
    return s;
  endfunction

  // Monitor: an input sampled at posedge k is visible after posedge k+1.
  always @(posedge clock) begin
    v2 = v1;
    v1 = drv_valid;
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (v2) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: output with no expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        check($sformatf("sym_t%0d", e.tag), tmdsOut, e.sym);
        if (e.act) begin
          bal += 2 * $countones(tmdsOut) - 10;
          checks++;
          if (bal > 10 || bal < -10) begin
            failures++;
            $display("FAIL dc_balance: running=%0d allowed=+/-10 at %0t", bal, $time);
          end
        end else begin
          bal = 0;
        end
      end
    end
  end

  task automatic issue(input bit d_e, input bit [1:0] c, input bit [7:0] d,
                       input logic [9:0] exp, input int tag);
    exp_t e;
    @(negedge clock);
    de = d_e; ctrl = c; data = d;
    drv_valid = 1'b1;
    e.sym = exp; e.act = d_e; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      de = 1'b0; ctrl = 2'b00; data = 8'h00;
      drv_valid = 1'b0;
    end
  endtask

  initial begin
    bit        de_r;
    bit [1:0]  c;
    bit [7:0]  d;
    int        active;
    logic [9:0] ex;

    resetN = 1'b1; de = 1'b0; ctrl = 2'b00; data = 8'h00;

    // 1: asynchronous reset and hold after release
    #12 resetN = 1'b0;
    #1 check("reset_async", tmdsOut, 10'h354);
    repeat (2) @(posedge clock);
    #1 check("reset_hold", tmdsOut, 10'h354);
    @(negedge clock);
    resetN = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("post_release", tmdsOut, 10'h354);
    end

    // 2: control symbols
    issue(1'b0, 2'b01, 8'($urandom), 10'h0AB, 2);
    issue(1'b0, 2'b10, 8'($urandom), 10'h154, 2);
    issue(1'b0, 2'b11, 8'($urandom), 10'h2AB, 2);

    // 3: data 00 x3 after blanking
    issue(1'b0, 2'b00, 8'h00, 10'h354, 3);
    issue(1'b1, 2'($urandom), 8'h00, 10'h100, 3);
    issue(1'b1, 2'($urandom), 8'h00, 10'h3FF, 3);
    issue(1'b1, 2'($urandom), 8'h00, 10'h100, 3);

    // 4: FF, one blanking cycle, then 00 must restart from cnt=0
    issue(1'b0, 2'b00, 8'h00, 10'h354, 4);
    issue(1'b1, 2'($urandom), 8'hFF, 10'h200, 4);
    issue(1'b0, 2'b00, 8'($urandom), 10'h354, 4);
    issue(1'b1, 2'($urandom), 8'h00, 10'h100, 4);

    // 5: random data with random blanking against the reference model
    m_cnt  = 0;
    de_r   = 1'b0;
    active = 0;
    c = 2'($urandom); d = 8'($urandom);
    ex = ref_sym(1'b0, c, d);
    issue(1'b0, c, d, ex, 5);
    while (active < 10000) begin
      if (de_r) begin
        if ($urandom_range(63) == 0) de_r = 1'b0;
      end else begin
        if ($urandom_range(3) == 0) de_r = 1'b1;
      end
      c  = 2'($urandom);
      d  = 8'($urandom);
      ex = ref_sym(de_r, c, d);
      issue(de_r, c, d, ex, 5);
      if (de_r) active++;
    end
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending=%0d expected=0", sb.size());
    end

    // 6: reset in the middle of an A5 run
    repeat (5) begin
      @(negedge clock);
      de = 1'b1; ctrl = 2'($urandom); data = 8'hA5;
    end
    #2 resetN = 1'b0;
    #1 check("reset_mid_run", tmdsOut, 10'h354);
    @(negedge clock);
    check("reset_mid_hold", tmdsOut, 10'h354);
    resetN = 1'b1; de = 1'b0; ctrl = 2'b00;
    @(negedge clock);
    check("rel_a", tmdsOut, 10'h354);
    de = 1'b1; data = 8'hA5;
    @(negedge clock);
    check("rel_b", tmdsOut, 10'h354);
    @(negedge clock);
    check("first_a5", tmdsOut, 10'h163);
    @(negedge clock);
    check("second_a5", tmdsOut, 10'h163);
    de = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
